// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 single-beat/INCR slave over one single-port synchronous SRAM.
// Independent read and write FSMs share the SRAM port; the read side wins the port.
module axi_sram_slave #(
  parameter int RAM_AW = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {R_IDLE, R_RD, R_CAP, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  rstate_t     r_rst;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [7:0]  r_rlen;
  logic [7:0]  r_rbeat;
  logic [1:0]  r_rsize;
  logic        r_rbad;
  logic [31:0] r_rdata;

  wstate_t     r_wst;
  logic [3:0]  r_bid;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wbeat;
  logic [1:0]  r_wsize;
  logic        r_wbad;
  logic        r_werr;

  logic w_rd;
  logic w_wbeat;
  logic w_unused;

  assign w_unused = ^wid;
  assign w_rd     = r_rst == R_RD;
  assign w_wbeat  = wvalid && wready;

  assign arready = r_rst == R_IDLE;
  assign rvalid  = r_rst == R_RESP;
  assign rlast   = rvalid && r_rbeat == r_rlen;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rbad ? 2'b10 : 2'b00;

  assign awready = r_wst == W_IDLE;
  assign wready  = r_wst == W_DATA && !w_rd;
  assign bvalid  = r_wst == W_RESP;
  assign bid     = r_bid;
  assign bresp   = (r_werr || r_wbad) ? 2'b10 : 2'b00;

  // bad-burst transfers keep their handshake timing but never touch the SRAM
  assign ram_en    = (w_rd && !r_rbad) || (w_wbeat && !r_wbad);
  assign ram_we    = (w_wbeat && !r_wbad) ? wstrb : 4'd0;
  assign ram_addr  = w_rd ? r_raddr[RAM_AW+1:2] : r_waddr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_rst   <= R_IDLE;
      r_rid   <= '0;
      r_raddr <= '0;
      r_rlen  <= '0;
      r_rbeat <= '0;
      r_rsize <= '0;
      r_rbad  <= 1'b0;
      r_rdata <= '0;
    end else
      case (r_rst)
        R_IDLE: if (arvalid) begin
          r_rid   <= arid;
          r_raddr <= araddr;
          r_rlen  <= arlen;
          r_rbeat <= '0;
          r_rsize <= (arsize > 3'd2) ? 2'd2 : arsize[1:0];
          r_rbad  <= arburst != 2'b01;
          r_rst   <= R_RD;
        end
        R_RD: r_rst <= R_CAP;
        R_CAP: begin
          r_rdata <= r_rbad ? '0 : ram_rdata;
          r_rst   <= R_RESP;
        end
        default: if (rready) begin
          r_rst   <= rlast ? R_IDLE : R_RD;
          r_raddr <= rlast ? r_raddr : r_raddr + (32'd1 << r_rsize);
          r_rbeat <= rlast ? r_rbeat : r_rbeat + 8'd1;
        end
      endcase

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_wst   <= W_IDLE;
      r_bid   <= '0;
      r_waddr <= '0;
      r_wlen  <= '0;
      r_wbeat <= '0;
      r_wsize <= '0;
      r_wbad  <= 1'b0;
      r_werr  <= 1'b0;
    end else
      case (r_wst)
        W_IDLE: if (awvalid) begin
          r_bid   <= awid;
          r_waddr <= awaddr;
          r_wlen  <= awlen;
          r_wbeat <= '0;
          r_wsize <= (awsize > 3'd2) ? 2'd2 : awsize[1:0];
          r_wbad  <= awburst != 2'b01;
          r_werr  <= 1'b0;
          r_wst   <= W_DATA;
        end
        W_DATA: if (w_wbeat) begin
          r_waddr <= r_waddr + (32'd1 << r_wsize);
          r_wbeat <= r_wbeat + 8'd1;
          r_werr  <= r_werr || (wlast != (r_wbeat == r_wlen));
          r_wst   <= (r_wbeat == r_wlen) ? W_RESP : W_DATA;
        end
        default: if (bready) r_wst <= W_IDLE;
      endcase
endmodule
